// File: rtl/can_crc_stuff_if.sv
// Control and bit-stream bundle between the frame transmitter and the CAN FD
// CRC-field serializer.
interface can_crc_stuff_if;
    localparam int unsigned SC_W  = 4;
    localparam int unsigned C17_W = 17;
    localparam int unsigned C21_W = 21;
    localparam int unsigned CNT_W = 9;

    logic             start;
    logic             abort;
    logic             fd_crc21;
    logic [SC_W-1:0]  stuff_cnt;
    logic [C17_W-1:0] crc_17_i;
    logic [C21_W-1:0] crc_21_i;
    logic             prev_bit;
    logic             tx_point;
    logic             tx_bit;
    logic             stuff_bit;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output start, abort, fd_crc21, stuff_cnt, crc_17_i, crc_21_i, prev_bit, tx_point,
        input  tx_bit, stuff_bit, busy, done, bit_cnt
    );

    modport slave (
        input  start, abort, fd_crc21, stuff_cnt, crc_17_i, crc_21_i, prev_bit, tx_point,
        output tx_bit, stuff_bit, busy, done, bit_cnt
    );
endinterface

// File: rtl/can_crc_stuff.sv
// CAN FD CRC-field serializer: shifts out {stuff_cnt, crc} MSB first with a
// fixed stuff bit before the first bit and after every four payload bits.
module can_crc_stuff (
    input  logic            clk,
    input  logic            rst_n,
    can_crc_stuff_if.slave  ctl
);
    localparam int unsigned SR_W  = 25;
    localparam int unsigned CNT_W = 9;
    localparam int unsigned GRP_W = 3;
    localparam logic [CNT_W-1:0] LAST17   = CNT_W'(26);
    localparam logic [CNT_W-1:0] LAST21   = CNT_W'(31);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(4);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [SR_W-1:0]   sh_q, sh_d;
    logic              crc21_q, crc21_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tx_q, tx_d;
    logic              st_q, st_d;
    logic              done_q, done_d;
    logic              last_c;

    assign last_c = (cnt_q == (crc21_q ? LAST21 : LAST17));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_d = state_q;
        if (ctl.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (ctl.start)                state_d = S_SEND;
                S_SEND: if (ctl.tx_point && last_c)   state_d = S_IDLE;
            endcase
        end
    end

    // Datapath / output next values
    always_comb begin
        sh_d    = sh_q;
        crc21_d = crc21_q;
        grp_d   = grp_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        st_d    = st_q;
        done_d  = 1'b0;
        if (ctl.abort) begin
            grp_d = '0;
            cnt_d = '0;
            tx_d  = 1'b1;
            st_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctl.start) begin
                        // CRC-17 payload is left-aligned; trailing zeros are never sent
                        sh_d    = ctl.fd_crc21 ? {ctl.stuff_cnt, ctl.crc_21_i}
                                               : {ctl.stuff_cnt, ctl.crc_17_i, 4'b0000};
                        crc21_d = ctl.fd_crc21;
                        grp_d   = '0;
                        cnt_d   = '0;
                        tx_d    = ~ctl.prev_bit;
                        st_d    = 1'b1;
                    end
                end
                S_SEND: begin
                    if (ctl.tx_point) begin
                        if (last_c) begin
                            grp_d  = '0;
                            cnt_d  = '0;
                            tx_d   = 1'b1;
                            st_d   = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                            grp_d = (grp_q == GRP_LAST) ? '0 : grp_q + GRP_W'(1);
                            if (grp_q == GRP_LAST) begin
                                tx_d = ~tx_q;
                                st_d = 1'b1;
                            end else begin
                                tx_d = sh_q[SR_W-1];
                                sh_d = {sh_q[SR_W-2:0], 1'b0};
                                st_d = 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= '0;
            crc21_q <= 1'b0;
            grp_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            st_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            crc21_q <= crc21_d;
            grp_q   <= grp_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            st_q    <= st_d;
            done_q  <= done_d;
        end
    end

    assign ctl.tx_bit    = tx_q;
    assign ctl.stuff_bit = st_q;
    assign ctl.busy      = (state_q == S_SEND);
    assign ctl.done      = done_q;
    assign ctl.bit_cnt   = cnt_q;
endmodule

// File: tb/tb_can_crc_stuff.sv
// Self-checking bench for can_crc_stuff: directed and randomized CRC fields
// compared against a queue-based model of the fixed-stuffing rule.
module tb_can_crc_stuff;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    can_crc_stuff_if bif ();

    can_crc_stuff dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(bif.busy), 32'd0);
        chk({tag, "_tx"},    32'(bif.tx_bit), 32'd1);
        chk({tag, "_stuff"}, 32'(bif.stuff_bit), 32'd0);
        chk({tag, "_cnt"},   32'(bif.bit_cnt), 32'd0);
    endtask

    // stop_kind: 0 = abort at stop_at, 1 = reset at stop_at
    task automatic run_field(input bit m21, input logic [3:0] sc, input logic [20:0] crc,
                             input bit prev, input int max_gap, input int stop_at,
                             input int stop_kind, input int mid_start_at, input bit start_with_tp,
                             output logic [31:0] seq);
        bit          exp_b[$];
        bit          exp_s[$];
        bit          last;
        bit          prevb;
        int          n;
        logic [24:0] p;
        logic [24:0] got_pl;
        n = m21 ? 25 : 21;
        p = m21 ? {sc, crc} : {sc, crc[16:0], 4'b0000};
        last = prev;
        for (int i = 0; i < n; i++) begin
            if (i % 4 == 0) begin
                exp_b.push_back(!last);
                exp_s.push_back(1'b1);
                last = !last;
            end
            exp_b.push_back(p[24-i]);
            exp_s.push_back(1'b0);
            last = p[24-i];
        end

        bif.fd_crc21  = m21;
        bif.stuff_cnt = sc;
        bif.crc_17_i  = crc[16:0];
        bif.crc_21_i  = crc;
        bif.prev_bit  = prev;
        bif.start     = 1'b1;
        bif.tx_point  = start_with_tp;
        @(negedge clk);
        bif.start    = 1'b0;
        bif.tx_point = 1'b0;
        // sampled-at-start inputs are don't-care once busy
        bif.fd_crc21  = 1'($urandom);
        bif.stuff_cnt = 4'($urandom);
        bif.crc_17_i  = 17'($urandom);
        bif.crc_21_i  = 21'($urandom);
        bif.prev_bit  = 1'($urandom);

        seq    = '0;
        got_pl = '0;
        prevb  = prev;
        for (int k = 0; k < exp_b.size(); k++) begin
            chk("tx_bit",    32'(bif.tx_bit),    32'(exp_b[k]));
            chk("stuff_bit", 32'(bif.stuff_bit), 32'(exp_s[k]));
            chk("bit_cnt",   32'(bif.bit_cnt),   32'(k));
            chk("busy",      32'(bif.busy),      32'd1);
            chk("done_low",  32'(bif.done),      32'd0);
            if (bif.stuff_bit) chk("stuff_compl", 32'(bif.tx_bit), 32'(!prevb));
            else got_pl = {got_pl[23:0], bif.tx_bit};
            prevb = bif.tx_bit;
            seq   = {seq[30:0], bif.tx_bit};

            if (k == stop_at) begin
                if (stop_kind == 0) begin
                    bif.abort    = 1'b1;
                    bif.tx_point = 1'b1;
                    bif.start    = 1'b1;
                    @(negedge clk);
                    bif.abort    = 1'b0;
                    bif.tx_point = 1'b0;
                    bif.start    = 1'b0;
                    chk_idle("abort");
                    chk("abort_done", 32'(bif.done), 32'd0);
                    @(negedge clk);
                    chk("abort_done2", 32'(bif.done), 32'd0);
                    chk("abort_busy2", 32'(bif.busy), 32'd0);
                end else begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk_idle("rst_async");
                    chk("rst_done", 32'(bif.done), 32'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    chk_idle("rst_rel");
                end
                return;
            end

            if (k == mid_start_at) begin
                bif.start = 1'b1;
                @(negedge clk);
                bif.start = 1'b0;
            end
            repeat ($urandom_range(max_gap - 1, 0)) @(negedge clk);
            chk("hold_tx",  32'(bif.tx_bit),  32'(exp_b[k]));
            chk("hold_cnt", 32'(bif.bit_cnt), 32'(k));
            bif.tx_point = 1'b1;
            @(negedge clk);
            bif.tx_point = 1'b0;
        end
        chk("done", 32'(bif.done), 32'd1);
        chk_idle("end");
        if (m21) chk("payload21", 32'(got_pl), 32'({sc, crc}));
        else     chk("payload17", 32'(got_pl[20:0]), 32'({sc, crc[16:0]}));
        @(negedge clk);
        chk("done_pulse", 32'(bif.done), 32'd0);
    endtask

    initial begin
        logic [31:0] seq;
        logic [31:0] lit;
        n_vec = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bif.start     = 1'b0;
        bif.abort     = 1'b0;
        bif.fd_crc21  = 1'b0;
        bif.stuff_cnt = '0;
        bif.crc_17_i  = '0;
        bif.crc_21_i  = '0;
        bif.prev_bit  = 1'b0;
        bif.tx_point  = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_done", 32'(bif.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // tx_point in IDLE has no effect
        bif.tx_point = 1'b1;
        @(negedge clk);
        bif.tx_point = 1'b0;
        @(negedge clk);
        chk_idle("idle_tp");

        // Directed CRC-17 vector
        run_field(1'b0, 4'hA, 21'h1FFFF, 1'b0, 3, -1, 0, -1, 1'b0, seq);
        lit = 32'(27'b1_1010_1_1111_0_1111_0_1111_0_1111_0_1);
        chk("seq17", 32'(seq[26:0]), lit);

        // Directed CRC-21 vector, start together with tx_point in IDLE
        run_field(1'b1, 4'h0, 21'h0, 1'b1, 4, -1, 0, -1, 1'b1, seq);
        lit = 32'b0_0000_1_0000_1_0000_1_0000_1_0000_1_0000_1_0;
        chk("seq21", seq, lit);

        // Random CRC-21 fields, strobe spacing 1..20; one with a mid-field start
        for (int r = 0; r < 8; r++)
            run_field(1'b1, 4'($urandom), 21'($urandom), 1'($urandom), 20, -1, 0,
                      (r == 2) ? 7 : -1, 1'b0, seq);

        // Abort at bit_cnt 12, then a clean restart
        run_field(1'b0, 4'($urandom), 21'($urandom), 1'($urandom), 3, 12, 0, -1, 1'b0, seq);
        run_field(1'b0, 4'($urandom), 21'($urandom), 1'($urandom), 3, -1, 0, -1, 1'b0, seq);

        // Reset at bit_cnt 20, then a full field
        run_field(1'b0, 4'($urandom), 21'($urandom), 1'($urandom), 3, 20, 1, -1, 1'b0, seq);
        run_field(1'b0, 4'hA, 21'h1FFFF, 1'b0, 2, -1, 0, -1, 1'b0, seq);
        lit = 32'(27'b1_1010_1_1111_0_1111_0_1111_0_1111_0_1);
        chk("seq17_post_rst", 32'(seq[26:0]), lit);

        // Back-to-back strobes, both modes
        for (int r = 0; r < 4; r++)
            run_field(1'(r), 4'($urandom), 21'($urandom), 1'($urandom), 1, -1, 0, -1, 1'b0, seq);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
